// File: rtl/conversor_bin_bcd_display_pkg.sv
// Shared types and constants for the binary to BCD display sequencer.
package conversor_bin_bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DESPLAZA  = 2'd1,
        ACTUALIZA = 2'd2
    } estado_t;

    localparam int MAX_DISPLAY = 9999;
    localparam int N_DIGITOS   = 5;
    localparam int ANCHO_BCD   = 4 * N_DIGITOS;
    localparam int ANCHO_PASO  = 5;

    // Four-digit packed BCD of a constant, used to build the saturation pattern.
    function automatic logic [15:0] a_bcd16(input int valor);
        logic [15:0] r;
        int          v;
        r = '0;
        v = valor;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/conversor_bin_bcd_display_ajuste_bcd.sv
// One double-dabble correction step on a single BCD nibble.
module ajuste_bcd (
    input  logic [3:0] nibble_i,
    output logic [3:0] nibble_o
);

    // Inputs never exceed 9 here, so +3 stays within the nibble.
    assign nibble_o = (nibble_i >= 4'd5) ? nibble_i + 4'd3 : nibble_i;

endmodule

// File: rtl/conversor_bin_bcd_display.sv
// Multi-cycle binary to 4-digit BCD converter; all digits update together on o_Hecho.
module conversor_bin_bcd_display
    import conversor_bin_bcd_display_pkg::*;
#(
    parameter int ANCHO_BIN = 14,
    parameter bit SATURAR   = 1'b1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [ANCHO_BIN-1:0] i_Valor,
    input  logic                 i_Valido,
    output logic                 o_Listo,
    output logic                 o_Hecho,
    output logic                 o_Desborde,
    output logic [3:0]           o_Datos_1,
    output logic [3:0]           o_Datos_2,
    output logic [3:0]           o_Datos_3,
    output logic [3:0]           o_Datos_4
);

    localparam logic [ANCHO_PASO-1:0] ULTIMO_PASO = ANCHO_PASO'(ANCHO_BIN - 1);
    localparam logic [15:0]           BCD_SAT     = a_bcd16(MAX_DISPLAY);

    estado_t                 estado_q, estado_d;
    logic [ANCHO_BIN-1:0]    bin_q, bin_d;
    logic [ANCHO_BCD-1:0]    bcd_q, bcd_d;
    logic [ANCHO_BCD-1:0]    bcd_aj;
    logic [ANCHO_PASO-1:0]   paso_q, paso_d;
    logic [15:0]             datos_q, datos_d;
    logic                    desborde_q, desborde_d;
    logic                    hecho_q, hecho_d;

    for (genvar g = 0; g < N_DIGITOS; g++) begin : g_ajuste
        ajuste_bcd u_ajuste (
            .nibble_i (bcd_q[4*g +: 4]),
            .nibble_o (bcd_aj[4*g +: 4])
        );
    end

    always_comb begin
        estado_d   = estado_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        paso_d     = paso_q;
        datos_d    = datos_q;
        desborde_d = desborde_q;
        hecho_d    = 1'b0;
        case (estado_q)
            IDLE: begin
                if (i_Valido) begin
                    bin_d    = i_Valor;
                    bcd_d    = '0;
                    paso_d   = '0;
                    estado_d = DESPLAZA;
                end
            end
            DESPLAZA: begin
                {bcd_d, bin_d} = {bcd_aj, bin_q} << 1;
                paso_d         = paso_q + 1'b1;
                if (paso_q == ULTIMO_PASO) begin
                    estado_d = ACTUALIZA;
                end
            end
            ACTUALIZA: begin
                // Fifth digit nonzero means the value does not fit on four digits.
                desborde_d = |bcd_q[19:16];
                datos_d    = (SATURAR && (|bcd_q[19:16])) ? BCD_SAT : bcd_q[15:0];
                hecho_d    = 1'b1;
                estado_d   = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            estado_q   <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            paso_q     <= '0;
            datos_q    <= '0;
            desborde_q <= 1'b0;
            hecho_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            paso_q     <= paso_d;
            datos_q    <= datos_d;
            desborde_q <= desborde_d;
            hecho_q    <= hecho_d;
        end
    end

    assign o_Listo    = (estado_q == IDLE);
    assign o_Hecho    = hecho_q;
    assign o_Desborde = desborde_q;
    assign o_Datos_1  = datos_q[3:0];
    assign o_Datos_2  = datos_q[7:4];
    assign o_Datos_3  = datos_q[11:8];
    assign o_Datos_4  = datos_q[15:12];

endmodule

// File: tb/tb_conversor_bin_bcd_display.sv
// Bench: saturating and wrapping instances share stimulus and are checked against a decimal model.
module tb_conversor_bin_bcd_display;

    localparam int ANCHO_BIN = 14;
    localparam int LATENCIA  = ANCHO_BIN + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 valido = 1'b0;
    logic [ANCHO_BIN-1:0] valor = '0;

    logic       listo_s, hecho_s, desb_s;
    logic [3:0] d1_s, d2_s, d3_s, d4_s;
    logic       listo_m, hecho_m, desb_m;
    logic [3:0] d1_m, d2_m, d3_m, d4_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conversor_bin_bcd_display #(.ANCHO_BIN(ANCHO_BIN), .SATURAR(1'b1)) dut_sat (
        .i_Clk(clk), .i_Rst(rst), .i_Valor(valor), .i_Valido(valido),
        .o_Listo(listo_s), .o_Hecho(hecho_s), .o_Desborde(desb_s),
        .o_Datos_1(d1_s), .o_Datos_2(d2_s), .o_Datos_3(d3_s), .o_Datos_4(d4_s)
    );

    conversor_bin_bcd_display #(.ANCHO_BIN(ANCHO_BIN), .SATURAR(1'b0)) dut_mod (
        .i_Clk(clk), .i_Rst(rst), .i_Valor(valor), .i_Valido(valido),
        .o_Listo(listo_m), .o_Hecho(hecho_m), .o_Desborde(desb_m),
        .o_Datos_1(d1_m), .o_Datos_2(d2_m), .o_Datos_3(d3_m), .o_Datos_4(d4_m)
    );

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nombre, act, exp, $time);
        end
    endtask

    // Decimal digits of v (mod 10000) packed as hex nibbles.
    function automatic logic [15:0] digitos(input int v);
        int r;
        r = v % 10000;
        return 16'((r / 1000) * 4096 + ((r / 100) % 10) * 256 + ((r / 10) % 10) * 16 + (r % 10));
    endfunction

    // Reference model: a conversion is a fixed delay from acceptance to a result.
    int          m_rest = 0;
    int          m_val  = 0;
    int          ciclo  = 0;
    bit          m_ok   = 1'b0;
    logic        m_hecho = 1'b0;
    logic        m_ovf   = 1'b0;
    logic [15:0] m_sat   = '0;
    logic [15:0] m_mod   = '0;

    always @(posedge clk) begin
        ciclo++;
        m_hecho = 1'b0;
        if (rst) begin
            m_rest = 0;
            m_sat  = '0;
            m_mod  = '0;
            m_ovf  = 1'b0;
            m_ok   = 1'b1;
        end else if (m_rest > 0) begin
            m_rest--;
            if (m_rest == 0) begin
                m_ovf   = (m_val > 9999);
                m_sat   = m_ovf ? digitos(9999) : digitos(m_val);
                m_mod   = digitos(m_val);
                m_hecho = 1'b1;
            end
        end else if (valido) begin
            m_val  = int'(valor);
            m_rest = LATENCIA;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("sat datos", {d4_s, d3_s, d2_s, d1_s}, m_sat);
            chk("sat desborde", desb_s, m_ovf);
            chk("sat hecho", hecho_s, m_hecho);
            chk("sat listo", listo_s, m_rest == 0);
            chk("mod datos", {d4_m, d3_m, d2_m, d1_m}, m_mod);
            chk("mod desborde", desb_m, m_ovf);
            chk("mod hecho", hecho_m, m_hecho);
            chk("mod listo", listo_m, m_rest == 0);
        end
    end

    // Call at the negedge right after the acceptance edge; lat = cycles to o_Hecho.
    task automatic espera_hecho(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (hecho_s === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic convierte(input int v, output int lat);
        @(negedge clk);
        valor  = ANCHO_BIN'(v);
        valido = 1'b1;
        @(negedge clk);
        valido = 1'b0;
        espera_hecho(lat);
    endtask

    initial begin
        int lat;
        int bajos;
        int marcas[$];

        // T1 reset
        repeat (2) @(negedge clk);
        chk("reset datos", {d4_s, d3_s, d2_s, d1_s}, 16'h0000);
        chk("reset desborde", desb_s, 1'b0);
        chk("reset hecho", hecho_s, 1'b0);
        chk("reset listo", listo_s, 1'b1);
        rst = 1'b0;

        // T2 basic conversion and latency
        convierte(1234, lat);
        chk("latencia 1234", lat, 15);
        chk("1234 datos", {d4_s, d3_s, d2_s, d1_s}, 16'h1234);
        chk("1234 desborde", desb_s, 1'b0);

        // T3 boundaries
        convierte(9999, lat);
        chk("9999 sat", {d4_s, d3_s, d2_s, d1_s}, 16'h9999);
        chk("9999 desborde", desb_s, 1'b0);
        convierte(10000, lat);
        chk("10000 sat", {d4_s, d3_s, d2_s, d1_s}, 16'h9999);
        chk("10000 sat desborde", desb_s, 1'b1);
        chk("10000 mod", {d4_m, d3_m, d2_m, d1_m}, 16'h0000);
        convierte(16383, lat);
        chk("16383 mod", {d4_m, d3_m, d2_m, d1_m}, 16'h6383);
        chk("16383 mod desborde", desb_m, 1'b1);
        chk("16383 sat", {d4_s, d3_s, d2_s, d1_s}, 16'h9999);
        convierte(0, lat);
        chk("cero latencia", lat, 15);
        chk("cero datos", {d4_s, d3_s, d2_s, d1_s}, 16'h0000);

        // T4 request mid-conversion is ignored; input change has no effect
        @(negedge clk);
        valor  = 14'd42;
        valido = 1'b1;
        @(negedge clk);
        valido = 1'b0;
        bajos  = 0;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 4) begin
                valor  = 14'd777;
                valido = 1'b1;
            end
            if (n == 5) valido = 1'b0;
            if (listo_s === 1'b0) bajos++;
            else break;
        end
        chk("listo bajo ciclos", bajos, 15);
        chk("0042 datos", {d4_s, d3_s, d2_s, d1_s}, 16'h0042);
        @(negedge clk);
        chk("0777 ignorado", listo_s, 1'b1);

        // Request raised during ACTUALIZA is taken in the following IDLE cycle
        @(negedge clk);
        valor  = 14'd100;
        valido = 1'b1;
        @(negedge clk);
        valido = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 14) begin
                valor  = 14'd321;
                valido = 1'b1;
            end
        end
        @(negedge clk);
        chk("listo tras actualiza", listo_s, 1'b1);
        chk("0100 datos", {d4_s, d3_s, d2_s, d1_s}, 16'h0100);
        @(negedge clk);
        valido = 1'b0;
        chk("aceptado tras actualiza", listo_s, 1'b0);
        espera_hecho(lat);
        chk("latencia 0321", lat, 15);
        chk("0321 datos", {d4_s, d3_s, d2_s, d1_s}, 16'h0321);

        // T5 back-to-back with valid held high
        @(negedge clk);
        valor  = 14'd5;
        valido = 1'b1;
        for (int n = 0; n < 120 && marcas.size() < 4; n++) begin
            @(negedge clk);
            if (hecho_s === 1'b1) begin
                marcas.push_back(ciclo);
                chk("0005 datos", {d4_s, d3_s, d2_s, d1_s}, 16'h0005);
            end
        end
        valido = 1'b0;
        chk("0005 conversiones", marcas.size(), 4);
        for (int i = 1; i < marcas.size(); i++) begin
            chk("periodo hecho", marcas[i] - marcas[i-1], 16);
        end
        repeat (20) @(negedge clk);

        // T6 reset mid-conversion
        convierte(1234, lat);
        chk("1234 previo", {d4_s, d3_s, d2_s, d1_s}, 16'h1234);
        @(negedge clk);
        valor  = 14'd4321;
        valido = 1'b1;
        @(negedge clk);
        valido = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abortado datos", {d4_s, d3_s, d2_s, d1_s}, 16'h0000);
        chk("abortado listo", listo_s, 1'b1);
        bajos = 0;
        repeat (30) begin
            @(negedge clk);
            if (hecho_s === 1'b1) bajos++;
        end
        chk("abortado sin hecho", bajos, 0);
        chk("abortado datos fin", {d4_s, d3_s, d2_s, d1_s}, 16'h0000);

        // Random stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 299) == 0);
            valido = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0:       valor = 14'd9999;
                1:       valor = 14'd10000;
                2:       valor = 14'd0;
                3:       valor = 14'd16383;
                default: valor = ANCHO_BIN'($urandom_range(0, 16383));
            endcase
        end
        rst    = 1'b0;
        valido = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
